// File: rtl/mux_stream_arb.sv
// N-input registered stream multiplexer: explicit-select or round-robin grant,
// one-entry output register with full-throughput back-pressure and source tag.
module mux_stream_arb #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_src,
    output logic                 out_valid,
    input  logic                 out_ready
);

    typedef enum logic {
        MODE_SELECT = 1'b0,
        MODE_RR     = 1'b1
    } mode_e;

    logic [WIDTH-1:0] data_q, data_d;
    logic [SELW-1:0]  src_q,  src_d;
    logic             valid_q, valid_d;
    logic [SELW-1:0]  ptr_q,  ptr_d;

    logic [N-1:0]     grant;
    logic [SELW-1:0]  grant_idx;
    logic             grant_any;
    logic             load_en;
    logic             xfer;

    // The register may accept a new word when empty or when being drained this cycle.
    assign load_en  = !rst && (!valid_q || out_ready);
    assign in_ready = {N{load_en}} & grant;
    assign xfer     = load_en && grant_any;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/for structure can leave a value held (inferred latch).
    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        if (mode_e'(mode) == MODE_SELECT) begin
            // An out-of-range sel matches no channel, so it grants nothing.
            for (int i = 0; i < N; i++) begin
                if (int'(sel) == i && in_valid[i]) begin
                    grant[i]  = 1'b1;
                    grant_idx = SELW'(i);
                    grant_any = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
                if (!grant_any && in_valid[idx]) begin
                    grant[idx] = 1'b1;
                    grant_idx  = SELW'(idx);
                    grant_any  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        data_d  = data_q;
        src_d   = src_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (xfer) begin
            valid_d = 1'b1;
            data_d  = in_data[int'(grant_idx)*WIDTH +: WIDTH];
            src_d   = grant_idx;
            if (mode_e'(mode) == MODE_RR) begin
                ptr_d = (int'(grant_idx) == N-1) ? '0 : SELW'(int'(grant_idx) + 1);
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data register is reset too, because out_data must read
            // zero out of reset rather than whatever was captured last.
            data_q  <= '0;
            src_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            src_q   <= src_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_data  = data_q;
    assign out_src   = src_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_stream_arb.sv
// Scoreboard bench for mux_stream_arb: stimulus pushes expected words, a
// monitor pops and compares whenever a word is drained by the consumer.
module tb_mux_stream_arb;

    localparam int WIDTH = 32;
    localparam int N     = 4;
    localparam int SELW  = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               mode;
    logic [SELW-1:0]    sel;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_src;
    logic               out_valid;
    logic               out_ready;

    logic [WIDTH-1:0]   d [N];

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SELW-1:0]  src;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    assign in_data = {d[3], d[2], d[1], d[0]};

    mux_stream_arb #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: check in_ready mid-cycle, queue the word expected from exp_src (-1 = none).
    task automatic cycle(input int exp_src);
        logic [N-1:0] r;
        r = '0;
        if (exp_src >= 0) r[exp_src] = 1'b1;
        @(negedge clk);
        check("in_ready", 32'(in_ready), 32'(r));
        if (exp_src >= 0) sb.push_back('{data: d[exp_src], src: SELW'(exp_src)});
        @(posedge clk);
        #1;
    endtask

    task automatic rst_cycle();
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data", out_data, 32'(0));
        check("rst_out_src", 32'(out_src), 32'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic stall_cycle(input logic [31:0] exp_data, input int exp_src);
        @(negedge clk);
        check("stall_in_ready", 32'(in_ready), 32'(0));
        check("stall_out_valid", 32'(out_valid), 32'(1));
        check("stall_out_data", out_data, exp_data);
        check("stall_out_src", 32'(out_src), 32'(exp_src));
        @(posedge clk);
        #1;
    endtask

    // Monitor: a word leaves the DUT when out_valid && out_ready at the next edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
                check("word_expected", 32'(sb.size() != 0), 32'(1));
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("out_data", out_data, mon_e.data);
                    check("out_src", 32'(out_src), 32'(mon_e.src));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        mode      = 1'b1;
        sel       = '0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) d[i] = 32'h100 + 32'(i);
        @(posedge clk);
        #1;

        // Reset with every producer valid.
        rst_cycle();
        rst_cycle();
        rst = 1'b0;

        // Round-robin, all valid: 0,1,2,3,0,1,2,3 back to back.
        for (int i = 0; i < 8; i++) cycle(i % N);

        // Round-robin, channels 1 and 3 valid.
        in_valid = 4'b1010;
        cycle(1); cycle(3); cycle(1); cycle(3);

        // Back-pressure after one transfer; stream resumes at channel 1.
        in_valid = 4'b1111;
        cycle(0);
        out_ready = 1'b0;
        stall_cycle(32'h100, 0);
        stall_cycle(32'h100, 0);
        stall_cycle(32'h100, 0);
        out_ready = 1'b1;
        cycle(1);

        // Bring ptr to 3, then explicit channel 1 twice, then round-robin resumes at 3.
        cycle(2);
        mode = 1'b0;
        sel  = 2'd1;
        cycle(1);
        cycle(1);
        mode = 1'b1;
        cycle(3);

        // Explicit select of channel 2.
        mode = 1'b0;
        sel  = 2'd2;
        d[2] = 32'hCAFE0002;
        cycle(2); cycle(2); cycle(2);
        in_valid = 4'b1011;
        cycle(-1);
        @(negedge clk);
        check("idle_out_valid", 32'(out_valid), 32'(0));
        @(posedge clk);
        #1;

        // Reset while a word is stalled in the register: it must be discarded.
        mode     = 1'b1;
        in_valid = 4'b1111;
        d[2]     = 32'h102;
        cycle(0);
        out_ready = 1'b0;
        rst       = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'(0));
        check("midrst_buffered", 32'(out_valid), 32'(1));
        @(posedge clk);
        #1;
        rst_cycle();
        rst       = 1'b0;
        out_ready = 1'b1;
        cycle(0);
        cycle(1);

        // Drain and confirm nothing is left over or still pending.
        in_valid = 4'b0000;
        cycle(-1);
        cycle(-1);
        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'(0));
        check("final_out_valid", 32'(out_valid), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
